fifo_to_axis: RTL and testbench

- Downstream read-side stage of the SRAM FIFO path.
- Pops {tdata, tlast} words from the FIFO read port and presents them as an AXI4-Stream master with full backpressure.
- Returns one credit pulse (output_inc) per word delivered, so the upstream writer can release queue space.
- Keeps a packet-framing state machine, a delivered-packet counter and a sticky protocol-error flag.

---
 rtl/fifo_to_axis_pkg.sv | 15 +
 rtl/fifo_to_axis_skid_buf2.sv | 58 +++++
 rtl/fifo_to_axis.sv | 111 +++++++++++
 tb/tb_fifo_to_axis.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_to_axis_pkg.sv
// Shared definitions for the FIFO-to-AXI-Stream read stage: FIFO word layout,
// framing state encoding and output buffer depth.
package fifo_to_axis_pkg;

    // FIFO read word is {tdata, tlast}: tlast in bit 0, data above it
    localparam int unsigned TLAST_BIT = 0;
    localparam int unsigned DATA_LSB  = 1;
    localparam int unsigned BUF_DEPTH = 2;

    typedef enum logic {
        ST_SOP = 1'b0,
        ST_MID = 1'b1
    } pkt_state_t;

endpackage

// File: rtl/fifo_to_axis_skid_buf2.sv
// Two-entry output buffer: head register feeds the stream, tail register
// absorbs the word still in flight when the consumer stalls.
module axis_skid_buf2
    import fifo_to_axis_pkg::*;
#(
    parameter int unsigned WIDTH = 257
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       occ,
    output logic [WIDTH-1:0] head_data
);

    localparam logic [1:0] FULL = 2'(BUF_DEPTH);

    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic [1:0]       occ_q;
    logic             do_pop;

    assign do_pop    = pop && (occ_q != 2'd0);
    assign occ       = occ_q;
    assign head_data = head_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q <= '0;
        end else if (push && !do_pop && (occ_q != FULL)) begin
            occ_q <= occ_q + 2'd1;
        end else if (!push && do_pop) begin
            occ_q <= occ_q - 2'd1;
        end
    end

    // Data registers carry no reset; occupancy alone says what is valid.
    always_ff @(posedge clk) begin
        if (push && do_pop) begin
            if (occ_q == 2'd1) begin
                head_q <= push_data;
            end else begin
                head_q <= tail_q;
                tail_q <= push_data;
            end
        end else if (push) begin
            if (occ_q == 2'd0) begin
                head_q <= push_data;
            end else if (occ_q == 2'd1) begin
                tail_q <= push_data;
            end
        end else if (do_pop) begin
            head_q <= tail_q;
        end
    end

endmodule

// File: rtl/fifo_to_axis.sv
// Read side of the SRAM FIFO path: pops {tdata, tlast} words, streams them as
// an AXI4-Stream master and returns one credit per delivered beat.
module fifo_to_axis
    import fifo_to_axis_pkg::*;
#(
    parameter int unsigned TDATA_WIDTH = 32,
    parameter int unsigned TUSER_WIDTH = 128,
    parameter int unsigned BUF_DEPTH   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cal_done,
    input  logic                     fifo_rempty,
    output logic                     fifo_rinc,
    input  logic                     fifo_dout_valid,
    input  logic [8*TDATA_WIDTH:0]   fifo_dout,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [8*TDATA_WIDTH-1:0] m_tdata,
    output logic [TDATA_WIDTH-1:0]   m_tkeep,
    output logic [TDATA_WIDTH-1:0]   m_tstrb,
    output logic                     m_tlast,
    output logic [TUSER_WIDTH-1:0]   m_tuser,
    output logic                     output_inc,
    output logic [31:0]              output_pkt_cnt,
    output logic                     in_packet,
    output logic                     protocol_err
);

    localparam int unsigned DW = 8 * TDATA_WIDTH;
    localparam int unsigned WW = DW + 1;

    logic [1:0]    occ;
    logic [WW-1:0] head;
    logic          inflight_q;
    logic          pop;
    logic          capture;
    logic [2:0]    level_after;
    logic          pkt_inc;
    pkt_state_t    state_q;
    pkt_state_t    state_d;

    assign pop     = m_tvalid & m_tready;
    assign capture = fifo_dout_valid & inflight_q;

    // A pop this cycle frees its slot for a read issued in the same cycle.
    assign level_after = {1'b0, occ} - {2'b00, pop} + {2'b00, inflight_q};
    assign fifo_rinc   = ~reset & cal_done & ~fifo_rempty & (level_after < 3'(BUF_DEPTH));

    axis_skid_buf2 #(
        .WIDTH (WW)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (capture),
        .push_data (fifo_dout),
        .pop       (pop),
        .occ       (occ),
        .head_data (head)
    );

    assign m_tvalid  = (occ != 2'd0);
    assign m_tdata   = head[DATA_LSB +: DW];
    assign m_tlast   = head[TLAST_BIT];
    assign m_tkeep   = '1;
    assign m_tstrb   = '1;
    assign m_tuser   = '0;
    assign in_packet = (state_q == ST_MID);

    always_comb begin
        state_d = state_q;
        pkt_inc = 1'b0;
        case (state_q)
            ST_SOP: begin
                if (pop && m_tlast) begin
                    pkt_inc = 1'b1;
                end else if (pop) begin
                    state_d = ST_MID;
                end
            end
            ST_MID: begin
                if (pop && m_tlast) begin
                    pkt_inc = 1'b1;
                    state_d = ST_SOP;
                end
            end
            default: state_d = ST_SOP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_SOP;
            inflight_q     <= 1'b0;
            output_inc     <= 1'b0;
            output_pkt_cnt <= '0;
            protocol_err   <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= fifo_rinc;
            output_inc <= pop;
            if (pkt_inc) begin
                output_pkt_cnt <= output_pkt_cnt + 32'd1;
            end
            if (fifo_dout_valid && !inflight_q) begin
                protocol_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_to_axis.sv
// Directed bench for fifo_to_axis: behavioural FIFO read port with one-cycle
// read latency, stream monitor and hand-computed expectations.
module tb_fifo_to_axis;

    localparam int unsigned TDW = 32;
    localparam int unsigned DW  = 8 * TDW;
    localparam int unsigned WW  = DW + 1;

    logic            clk;
    logic            reset;
    logic            cal_done;
    logic            fifo_rempty;
    logic            fifo_rinc;
    logic            fifo_dout_valid;
    logic [DW:0]     fifo_dout;
    logic            m_tvalid;
    logic            m_tready;
    logic [DW-1:0]   m_tdata;
    logic [TDW-1:0]  m_tkeep;
    logic [TDW-1:0]  m_tstrb;
    logic            m_tlast;
    logic [127:0]    m_tuser;
    logic            output_inc;
    logic [31:0]     output_pkt_cnt;
    logic            in_packet;
    logic            protocol_err;

    fifo_to_axis #(
        .TDATA_WIDTH (TDW),
        .TUSER_WIDTH (128),
        .BUF_DEPTH   (2)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .cal_done        (cal_done),
        .fifo_rempty     (fifo_rempty),
        .fifo_rinc       (fifo_rinc),
        .fifo_dout_valid (fifo_dout_valid),
        .fifo_dout       (fifo_dout),
        .m_tvalid        (m_tvalid),
        .m_tready        (m_tready),
        .m_tdata         (m_tdata),
        .m_tkeep         (m_tkeep),
        .m_tstrb         (m_tstrb),
        .m_tlast         (m_tlast),
        .m_tuser         (m_tuser),
        .output_inc      (output_inc),
        .output_pkt_cnt  (output_pkt_cnt),
        .in_packet       (in_packet),
        .protocol_err    (protocol_err)
    );

    logic [WW-1:0] fifo_q[$];
    logic [WW-1:0] exp_q[$];
    logic [WW-1:0] rx_q[$];
    int            beat_cyc_q[$];
    bit            inpk_q[$];

    int            tests;
    int            fails;
    int            cyc;
    int            rinc_cnt;
    int            inc_cnt;
    int            rinc_first;
    int            tv_first;
    logic          inj_req;
    logic          nxt_dv;
    logic [WW-1:0] nxt_word;

    always #5 clk = ~clk;

    // Monitor and FIFO model: observe mid-cycle, apply read data after the edge.
    always @(negedge clk) begin
        cyc++;
        if (output_inc) inc_cnt++;
        if (fifo_rinc) begin
            rinc_cnt++;
            if (rinc_first < 0) rinc_first = cyc;
        end
        if (m_tvalid && tv_first < 0) tv_first = cyc;
        if (!reset && m_tvalid && m_tready) begin
            rx_q.push_back({m_tdata, m_tlast});
            beat_cyc_q.push_back(cyc);
            inpk_q.push_back(in_packet);
        end
        nxt_dv   = inj_req;
        nxt_word = '1;
        if (fifo_rinc) begin
            if (fifo_q.size() > 0) nxt_word = fifo_q.pop_front();
            nxt_dv = 1'b1;
        end
    end

    always @(posedge clk) begin
        #1;
        fifo_dout_valid = nxt_dv;
        fifo_dout       = nxt_word;
        fifo_rempty     = (fifo_q.size() == 0);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [WW-1:0] mk(input int id, input bit last);
        logic [31:0] w;
        w = 32'(id);
        return {{8{w}}, last};
    endfunction

    task automatic push_word(input int id, input bit last);
        logic [WW-1:0] w;
        w = mk(id, last);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        rx_q.delete();
        exp_q.delete();
        beat_cyc_q.delete();
        inpk_q.delete();
    endtask

    task automatic wait_rx(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (rx_q.size() < n && k < budget) begin
            step(1);
            k++;
        end
        check(tag, 64'(rx_q.size()), 64'(n));
    endtask

    task automatic check_seq(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < rx_q.size()) begin
                check(tag, rx_q[i][63:0], exp_q[i][63:0]);
                if (rx_q[i] !== exp_q[i]) bad++;
            end else begin
                bad++;
            end
        end
        check({tag, "_full"}, 64'(bad), 64'd0);
    endtask

    function automatic int inpk_sum();
        int s;
        s = 0;
        foreach (inpk_q[i]) s += int'(inpk_q[i]);
        return s;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int inc0;
        int k;
        logic [31:0] pkt0;

        tests = 0; fails = 0; cyc = 0; rinc_cnt = 0; inc_cnt = 0;
        rinc_first = -1; tv_first = -1;
        clk = 1'b0; reset = 1'b1; cal_done = 1'b0; m_tready = 1'b0; inj_req = 1'b0;
        fifo_rempty = 1'b1; fifo_dout_valid = 1'b0; fifo_dout = '0;

        // Reset values
        step(3);
        check("rst_rinc", 64'(fifo_rinc), 64'd0);
        check("rst_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_inc", 64'(output_inc), 64'd0);
        check("rst_pkt", 64'(output_pkt_cnt), 64'd0);
        check("rst_inpkt", 64'(in_packet), 64'd0);
        check("rst_err", 64'(protocol_err), 64'd0);
        check("rst_tkeep", 64'(m_tkeep), 64'hFFFF_FFFF);
        check("rst_tuser", m_tuser[63:0], 64'd0);
        reset = 1'b0;
        step(1);

        // 4-word packet, ready held high
        clear_logs();
        rinc_first = -1; tv_first = -1;
        r0 = rinc_cnt; inc0 = inc_cnt;
        cal_done = 1'b1; m_tready = 1'b1;
        for (int i = 1; i <= 4; i++) push_word(i, i == 4);
        wait_rx("p4_count", 4, 50);
        step(3);
        check("p4_latency", 64'(tv_first - rinc_first), 64'd2);
        check("p4_consec", 64'(beat_cyc_q[3] - beat_cyc_q[0]), 64'd3);
        check_seq("p4_seq");
        check("p4_rinc", 64'(rinc_cnt - r0), 64'd4);
        check("p4_inc", 64'(inc_cnt - inc0), 64'd4);
        check("p4_pkt", 64'(output_pkt_cnt), 64'd1);
        check("p4_inpkt_first", 64'(inpk_q[0]), 64'd0);
        check("p4_inpkt_sum", 64'(inpk_sum()), 64'd3);
        check("p4_inpkt_end", 64'(in_packet), 64'd0);

        // Backpressure: ready low for a while with the FIFO non-empty
        clear_logs();
        m_tready = 1'b0;
        r0 = rinc_cnt; inc0 = inc_cnt;
        for (int i = 10; i <= 15; i++) push_word(i, i == 15);
        step(3);
        check("bp_head_a", m_tdata[63:0], exp_q[0][64:1]);
        step(9);
        check("bp_rinc", 64'(rinc_cnt - r0), 64'd2);
        check("bp_tvalid", 64'(m_tvalid), 64'd1);
        check("bp_head_b", m_tdata[63:0], exp_q[0][64:1]);
        check("bp_no_inc", 64'(inc_cnt - inc0), 64'd0);
        check("bp_no_rx", 64'(rx_q.size()), 64'd0);
        m_tready = 1'b1;
        wait_rx("bp_count", 6, 50);
        step(3);
        check_seq("bp_seq");
        check("bp_pkt", 64'(output_pkt_cnt), 64'd2);
        check("bp_inc", 64'(inc_cnt - inc0), 64'd6);

        // 200 single-beat packets under random ready
        clear_logs();
        pkt0 = output_pkt_cnt; inc0 = inc_cnt;
        for (int i = 0; i < 200; i++) push_word(100 + i, 1'b1);
        k = 0;
        while (rx_q.size() < 200 && k < 3000) begin
            m_tready = 1'($urandom_range(0, 1));
            step(1);
            k++;
        end
        m_tready = 1'b1;
        check("rnd_count", 64'(rx_q.size()), 64'd200);
        step(3);
        check_seq("rnd_seq");
        check("rnd_pkt", 64'(output_pkt_cnt - pkt0), 64'd200);
        check("rnd_inc", 64'(inc_cnt - inc0), 64'd200);

        // cal_done low blocks reads; dropping it after a read keeps the inflight word
        clear_logs();
        r0 = rinc_cnt;
        cal_done = 1'b0;
        push_word(500, 1'b0);
        push_word(501, 1'b0);
        push_word(502, 1'b1);
        step(10);
        check("cal_no_rinc", 64'(rinc_cnt - r0), 64'd0);
        check("cal_no_tvalid", 64'(m_tvalid), 64'd0);
        cal_done = 1'b1;
        k = 0;
        while (rinc_cnt == r0 && k < 20) begin
            step(1);
            k++;
        end
        cal_done = 1'b0;
        check("cal_rinc_seen", 64'(rinc_cnt - r0), 64'd1);
        step(10);
        check("cal_one_rinc", 64'(rinc_cnt - r0), 64'd1);
        check("cal_inflight_rx", 64'(rx_q.size()), 64'd1);
        check("cal_inflight_word", rx_q.size() > 0 ? rx_q[0][63:0] : 64'd0, exp_q[0][63:0]);
        cal_done = 1'b1;
        wait_rx("cal_count", 3, 50);
        check_seq("cal_seq");

        // Spurious read-data strobe
        clear_logs();
        step(3);
        check("err_pre", 64'(protocol_err), 64'd0);
        inj_req = 1'b1;
        step(1);
        inj_req = 1'b0;
        step(4);
        check("err_set", 64'(protocol_err), 64'd1);
        check("err_no_tvalid", 64'(m_tvalid), 64'd0);
        check("err_no_rx", 64'(rx_q.size()), 64'd0);
        push_word(600, 1'b0);
        push_word(601, 1'b1);
        wait_rx("err_count", 2, 50);
        check_seq("err_seq");
        check("err_sticky", 64'(protocol_err), 64'd1);

        // Reset mid-packet with a full buffer
        clear_logs();
        m_tready = 1'b0;
        for (int i = 700; i <= 704; i++) push_word(i, i == 704);
        step(10);
        m_tready = 1'b1;
        step(1);
        m_tready = 1'b0;
        step(5);
        check("mr_one_beat", 64'(rx_q.size()), 64'd1);
        check("mr_inpkt", 64'(in_packet), 64'd1);
        check("mr_full", 64'(m_tvalid), 64'd1);
        inc0 = inc_cnt;
        reset = 1'b1;
        fifo_q.delete();
        step(1);
        check("mr_tvalid_next", 64'(m_tvalid), 64'd0);
        reset = 1'b0;
        step(1);
        check("mr_tvalid", 64'(m_tvalid), 64'd0);
        check("mr_inpkt_clr", 64'(in_packet), 64'd0);
        check("mr_pkt_clr", 64'(output_pkt_cnt), 64'd0);
        check("mr_err_clr", 64'(protocol_err), 64'd0);
        check("mr_no_inc", 64'(inc_cnt - inc0), 64'd0);
        clear_logs();
        inc0 = inc_cnt;
        for (int i = 800; i <= 802; i++) push_word(i, i == 802);
        m_tready = 1'b1;
        wait_rx("mr_count", 3, 50);
        step(3);
        check_seq("mr_seq");
        check("mr_pkt", 64'(output_pkt_cnt), 64'd1);
        check("mr_inpkt_sum", 64'(inpk_sum()), 64'd2);
        check("mr_inc", 64'(inc_cnt - inc0), 64'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
